// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier, WIDTH+1 cycle fixed latency, signed/unsigned per operation.
// Optional overflow flag enabled by defining MULT_OVF_FLAG_EN.
module seq_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
`ifdef MULT_OVF_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  mreg;
  logic              neg;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] res;

  // Magnitude fits in WIDTH unsigned bits even for the most-negative value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

`ifdef MULT_OVF_FLAG_EN
  logic sgn_mode;

  function automatic logic ovf_of(input logic [2*WIDTH-1:0] p, input logic sgn);
    if (sgn)
      return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
    else
      return p[2*WIDTH-1:WIDTH] != '0;
  endfunction
`endif

  assign sum = {1'b0, acc} + {1'b0, mcand};
  assign raw = {acc, mreg};
  assign res = apply_sign(raw, neg);

  // Control and result registers: asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
`ifdef MULT_OVF_FLAG_EN
      overflow   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          {product_hi, product_lo} <= res;
`ifdef MULT_OVF_FLAG_EN
          overflow <= ovf_of(res, sgn_mode);
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers: no reset needed, always loaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      mcand <= magnitude(a, signed_mode);
      mreg  <= magnitude(b, signed_mode);
      neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc   <= '0;
`ifdef MULT_OVF_FLAG_EN
      sgn_mode <= signed_mode;
`endif
    end else if (state == RUN) begin
      if (mreg[0])
        {acc, mreg} <= {sum, mreg[WIDTH-1:1]};
      else
        {acc, mreg} <= {1'b0, acc, mreg[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param (WIDTH=16): directed corners plus randomized operands.
module tb_seq_mult_param;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;
`ifdef MULT_OVF_FLAG_EN
  logic         overflow;
`endif

  seq_mult_param #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_mode(signed_mode),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product_hi(product_hi),
    .product_lo(product_lo)
`ifdef MULT_OVF_FLAG_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;

  // Reference: plain integer multiplication with the operands' interpretation.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    exp_t   e;
    longint p;
    if (sm) begin
      p = longint'($signed(x)) * longint'($signed(y));
      e.ovf = (p < -32768) || (p > 32767);
    end else begin
      p = longint'(x) * longint'(y);
      e.ovf = (p > 65535);
    end
    e.prod = p[2*W-1:0];
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: compares every done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", {product_hi, product_lo}, e.prod);
        check("busy_at_done", busy, 0);
`ifdef MULT_OVF_FLAG_EN
        check("overflow", overflow, e.ovf);
`endif
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    a = x;
    b = y;
    signed_mode = sm;
    start = 1'b1;
    exp_q.push_back(model(x, y, sm));
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom();
    b = $urandom();
    check("busy_after_start", busy, 1);
  endtask

  // Counts edges after acceptance until done; optionally re-pulses start while busy.
  task automatic wait_done(input bit disturb);
    int cyc = 0;
    bit got = 0;
    bit busy_ok = 1;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      cyc++;
      #1;
      if (disturb) begin
        if (cyc == 2 || cyc == 9) begin
          start = 1'b1;
          a = 16'h1234;
          b = 16'h1234;
        end else begin
          start = 1'b0;
        end
      end
      if (done) got = 1;
      else if (!busy) busy_ok = 0;
    end
    check("latency", got ? cyc : -1, 17);
    check("busy_window", busy_ok, 1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    @(negedge clk);
    issue(x, y, sm);
    accept();
    wait_done(1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", {product_hi, product_lo}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'h0003, 16'hFFFB, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b1);
    run_op(16'h8000, 16'h0002, 1'b0);
    run_op(16'h0000, 16'h8000, 1'b1);
    run_op(16'h7FFF, 16'h8000, 1'b1);

    // start pulses while busy must not disturb the running operation
    @(negedge clk);
    issue(16'h00F3, 16'h0A01, 1'b0);
    accept();
    wait_done(1'b1);

    // new request in the done cycle chains directly
    run_op(16'h1111, 16'h0003, 1'b0);
    issue(16'h0002, 16'h0007, 1'b0);
    accept();
    wait_done(1'b0);
    check("chain_product_direct", {product_hi, product_lo}, 32'h0000_000E);

    // asynchronous abort mid-operation
    @(negedge clk);
    issue(16'hABCD, 16'h1234, 1'b0);
    accept();
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", {product_hi, product_lo}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run_op(16'h0101, 16'h0202, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
